fractal_sync_lock_ctrl: RTL and testbench

Per-port lock-session sequencer and free arbiter placed in front of the multi-port lock queue (fractal_sync_mp_queue).
- Turns each requester's acquire/release handshakes into the queue's single-cycle lock and free strobes.
- Tracks each session through grant.
- Arbitrates frees round-robin so that two ports never free the same register index in the same cycle. The queue ORs such frees into one pop, which would lose a free.

---
 rtl/fractal_sync_lock_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fractal_sync_lock_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_lock_ctrl.sv
// Per-port lock-session sequencer with a round-robin, index-aware free arbiter in front of fractal_sync_mp_queue.
// Optional grant-wait timeout monitor: define FRACTAL_SYNC_LOCK_TIMEOUT_EN.
module fractal_sync_lock_ctrl #(
    parameter int  N_PORTS        = 2,
    parameter int  IDX_WIDTH      = 1,
    parameter type element_t      = logic,
    parameter int  TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 acq_valid_i    [N_PORTS],
    input  logic [IDX_WIDTH-1:0] acq_idx_i      [N_PORTS],
    input  element_t             acq_element_i  [N_PORTS],
    output logic                 acq_ready_o    [N_PORTS],
    output logic                 gnt_o          [N_PORTS],
    output element_t             gnt_element_o  [N_PORTS],
    input  logic                 rel_valid_i    [N_PORTS],
    output logic                 rel_ready_o    [N_PORTS],
    output logic                 err_overflow_o [N_PORTS],
    output logic                 timeout_o      [N_PORTS],
    output logic                 q_lock_o       [N_PORTS],
    output logic                 q_free_o       [N_PORTS],
    output logic [IDX_WIDTH-1:0] q_idx_o        [N_PORTS],
    output logic                 q_idx_valid_o  [N_PORTS],
    output element_t             q_element_o    [N_PORTS],
    input  logic                 q_grant_i      [N_PORTS],
    input  element_t             q_element_i    [N_PORTS],
    input  logic                 q_overflow_i   [N_PORTS]
);

    // Handshakes: acquire transfers when acq_valid_i && acq_ready_o, release when rel_valid_i && rel_ready_o,
    // both on the rising clk_i edge; ready never depends on valid.

    localparam int RR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_WAIT,
        S_HELD,
        S_FREE
    } state_e;

    state_e                 state_q    [N_PORTS];
    logic [IDX_WIDTH-1:0]   idx_q      [N_PORTS];
    element_t               elem_q     [N_PORTS];
    element_t               gnt_elem_q [N_PORTS];
    logic                   err_q      [N_PORTS];
    logic                   free_sel   [N_PORTS];
    logic [RR_W-1:0]        rr_ptr_q;
    logic [RR_W-1:0]        rr_ptr_d;

`ifdef FRACTAL_SYNC_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt_q [N_PORTS];
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Scan from rr_ptr_q; a port loses only to an earlier-scanned winner freeing the same index,
    // since the queue would merge same-index frees into a single pop.
    always_comb begin
        int p;
        int q;
        logic conflict;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < N_PORTS; k++) free_sel[k] = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            p = int'(rr_ptr_q) + i;
            if (p >= N_PORTS) p = p - N_PORTS;
            conflict = 1'b0;
            for (int j = 0; j < i; j++) begin
                q = int'(rr_ptr_q) + j;
                if (q >= N_PORTS) q = q - N_PORTS;
                if (free_sel[q] && (idx_q[q] == idx_q[p])) conflict = 1'b1;
            end
            if ((state_q[p] == S_FREE) && !conflict) begin
                free_sel[p] = 1'b1;
                rr_ptr_d    = (p + 1 >= N_PORTS) ? '0 : RR_W'(p + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                state_q[p]    <= S_IDLE;
                idx_q[p]      <= '0;
                elem_q[p]     <= '0;
                gnt_elem_q[p] <= '0;
                err_q[p]      <= 1'b0;
`ifdef FRACTAL_SYNC_LOCK_TIMEOUT_EN
                wait_cnt_q[p] <= '0;
`endif
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int p = 0; p < N_PORTS; p++) begin
                err_q[p] <= 1'b0;
                case (state_q[p])
                    S_IDLE: begin
                        if (acq_valid_i[p]) begin
                            idx_q[p]   <= acq_idx_i[p];
                            elem_q[p]  <= acq_element_i[p];
                            state_q[p] <= S_LOCK;
                        end
                    end
                    S_LOCK: begin
                        if (q_overflow_i[p]) begin
                            err_q[p]   <= 1'b1;
                            state_q[p] <= S_IDLE;
                        end else begin
                            state_q[p] <= S_WAIT;
`ifdef FRACTAL_SYNC_LOCK_TIMEOUT_EN
                            wait_cnt_q[p] <= '0;
`endif
                        end
                    end
                    S_WAIT: begin
                        if (q_grant_i[p]) begin
                            gnt_elem_q[p] <= q_element_i[p];
                            state_q[p]    <= S_HELD;
                        end
`ifdef FRACTAL_SYNC_LOCK_TIMEOUT_EN
                        if (wait_cnt_q[p] != CNT_MAX) wait_cnt_q[p] <= wait_cnt_q[p] + 1'b1;
`endif
                    end
                    S_HELD: begin
                        if (rel_valid_i[p]) state_q[p] <= S_FREE;
                    end
                    S_FREE: begin
                        if (free_sel[p]) state_q[p] <= S_IDLE;
                    end
                    default: state_q[p] <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            acq_ready_o[p]    = (state_q[p] == S_IDLE);
            gnt_o[p]          = (state_q[p] == S_HELD);
            rel_ready_o[p]    = (state_q[p] == S_HELD);
            q_lock_o[p]       = (state_q[p] == S_LOCK);
            q_free_o[p]       = (state_q[p] == S_FREE) && free_sel[p];
            q_idx_valid_o[p]  = (state_q[p] == S_LOCK) || (state_q[p] == S_WAIT)
                              || ((state_q[p] == S_FREE) && free_sel[p]);
            q_idx_o[p]        = idx_q[p];
            q_element_o[p]    = elem_q[p];
            gnt_element_o[p]  = gnt_elem_q[p];
            err_overflow_o[p] = err_q[p];
`ifdef FRACTAL_SYNC_LOCK_TIMEOUT_EN
            timeout_o[p]      = (state_q[p] == S_WAIT) && (wait_cnt_q[p] == CNT_MAX);
`else
            timeout_o[p]      = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_fractal_sync_lock_ctrl.sv
// Directed self-checking bench for fractal_sync_lock_ctrl (two ports, 2-bit index, 8-bit element).
module tb_fractal_sync_lock_ctrl;

    localparam int NP = 2;
    localparam int IW = 2;
    typedef logic [7:0] elem_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          acq_valid_i    [NP];
    logic [IW-1:0] acq_idx_i      [NP];
    elem_t         acq_element_i  [NP];
    logic          acq_ready_o    [NP];
    logic          gnt_o          [NP];
    elem_t         gnt_element_o  [NP];
    logic          rel_valid_i    [NP];
    logic          rel_ready_o    [NP];
    logic          err_overflow_o [NP];
    logic          timeout_o      [NP];
    logic          q_lock_o       [NP];
    logic          q_free_o       [NP];
    logic [IW-1:0] q_idx_o        [NP];
    logic          q_idx_valid_o  [NP];
    elem_t         q_element_o    [NP];
    logic          q_grant_i      [NP];
    elem_t         q_element_i    [NP];
    logic          q_overflow_i   [NP];

    int checks = 0;
    int failures = 0;

    fractal_sync_lock_ctrl #(
        .N_PORTS(NP), .IDX_WIDTH(IW), .element_t(elem_t), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .acq_valid_i(acq_valid_i), .acq_idx_i(acq_idx_i), .acq_element_i(acq_element_i),
        .acq_ready_o(acq_ready_o), .gnt_o(gnt_o), .gnt_element_o(gnt_element_o),
        .rel_valid_i(rel_valid_i), .rel_ready_o(rel_ready_o),
        .err_overflow_o(err_overflow_o), .timeout_o(timeout_o),
        .q_lock_o(q_lock_o), .q_free_o(q_free_o), .q_idx_o(q_idx_o),
        .q_idx_valid_o(q_idx_valid_o), .q_element_o(q_element_o),
        .q_grant_i(q_grant_i), .q_element_i(q_element_i), .q_overflow_i(q_overflow_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) begin
            acq_valid_i[p] = 1'b0; acq_idx_i[p] = '0; acq_element_i[p] = '0;
            rel_valid_i[p] = 1'b0; q_grant_i[p] = 1'b0; q_element_i[p] = '0;
            q_overflow_i[p] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // Acquire on the masked ports, grant one cycle after the lock strobe, end in HELD.
    task automatic bring_up(input logic m0, input logic m1, input logic [IW-1:0] i0,
                            input logic [IW-1:0] i1, input elem_t e0, input elem_t e1);
        acq_valid_i[0] = m0; acq_idx_i[0] = i0; acq_element_i[0] = e0;
        acq_valid_i[1] = m1; acq_idx_i[1] = i1; acq_element_i[1] = e1;
        step();
        acq_valid_i[0] = 1'b0; acq_valid_i[1] = 1'b0;
        check("bu_lock0", 32'(q_lock_o[0]), 32'(m0));
        check("bu_lock1", 32'(q_lock_o[1]), 32'(m1));
        step();
        q_grant_i[0] = m0; q_element_i[0] = e0;
        q_grant_i[1] = m1; q_element_i[1] = e1;
        step();
        q_grant_i[0] = 1'b0; q_grant_i[1] = 1'b0;
        check("bu_gnt0", 32'(gnt_o[0]), 32'(m0));
        check("bu_gnt1", 32'(gnt_o[1]), 32'(m1));
    endtask

    initial begin
        clear_inputs();
        #2;
        check("rst_acq_ready0", 32'(acq_ready_o[0]), 32'd1);
        check("rst_acq_ready1", 32'(acq_ready_o[1]), 32'd1);
        check("rst_gnt0", 32'(gnt_o[0]), 32'd0);
        check("rst_qidx0", 32'(q_idx_o[0]), 32'd0);
        check("rst_qlock1", 32'(q_lock_o[1]), 32'd0);
        do_reset();

        // 1: single session, minimum latency
        acq_valid_i[0] = 1'b1; acq_idx_i[0] = 2'd3; acq_element_i[0] = 8'h01;
        check("t1_c0_ready", 32'(acq_ready_o[0]), 32'd1);
        step();
        acq_valid_i[0] = 1'b0;
        check("t1_c1_lock", 32'(q_lock_o[0]), 32'd1);
        check("t1_c1_idx", 32'(q_idx_o[0]), 32'd3);
        check("t1_c1_idxv", 32'(q_idx_valid_o[0]), 32'd1);
        check("t1_c1_elem", 32'(q_element_o[0]), 32'h01);
        step();
        check("t1_c2_lock", 32'(q_lock_o[0]), 32'd0);
        check("t1_c2_idxv", 32'(q_idx_valid_o[0]), 32'd1);
        check("t1_c2_gnt", 32'(gnt_o[0]), 32'd0);
        q_grant_i[0] = 1'b1; q_element_i[0] = 8'h01;
        step();
        q_grant_i[0] = 1'b0; q_element_i[0] = 8'h00;
        check("t1_c3_gnt", 32'(gnt_o[0]), 32'd1);
        check("t1_c3_gelem", 32'(gnt_element_o[0]), 32'h01);
        check("t1_c3_relrdy", 32'(rel_ready_o[0]), 32'd1);
        check("t1_c3_acqrdy", 32'(acq_ready_o[0]), 32'd0);
        rel_valid_i[0] = 1'b1;
        step();
        rel_valid_i[0] = 1'b0;
        check("t1_free", 32'(q_free_o[0]), 32'd1);
        check("t1_free_idxv", 32'(q_idx_valid_o[0]), 32'd1);
        check("t1_free_idx", 32'(q_idx_o[0]), 32'd3);
        check("t1_free_gnt", 32'(gnt_o[0]), 32'd0);
        step();
        check("t1_idle_ready", 32'(acq_ready_o[0]), 32'd1);
        check("t1_idle_free", 32'(q_free_o[0]), 32'd0);
        check("t1_idle_idx", 32'(q_idx_o[0]), 32'd3);
        check("t1_rr", 32'(dut.rr_ptr_q), 32'd1);
        do_reset();

        // 2: same-index frees serialise
        bring_up(1'b1, 1'b1, 2'd2, 2'd2, 8'h11, 8'h22);
        check("t2_gelem1", 32'(gnt_element_o[1]), 32'h22);
        rel_valid_i[0] = 1'b1; rel_valid_i[1] = 1'b1;
        step();
        rel_valid_i[0] = 1'b0; rel_valid_i[1] = 1'b0;
        check("t2_k_free0", 32'(q_free_o[0]), 32'd1);
        check("t2_k_free1", 32'(q_free_o[1]), 32'd0);
        check("t2_k_idxv1", 32'(q_idx_valid_o[1]), 32'd0);
        step();
        check("t2_k1_free0", 32'(q_free_o[0]), 32'd0);
        check("t2_k1_free1", 32'(q_free_o[1]), 32'd1);
        step();
        check("t2_rr", 32'(dut.rr_ptr_q), 32'd0);
        check("t2_ready0", 32'(acq_ready_o[0]), 32'd1);
        check("t2_ready1", 32'(acq_ready_o[1]), 32'd1);

        // 3: distinct-index frees share a cycle
        bring_up(1'b1, 1'b1, 2'd1, 2'd2, 8'hA5, 8'h5A);
        check("t3_gelem0", 32'(gnt_element_o[0]), 32'hA5);
        rel_valid_i[0] = 1'b1; rel_valid_i[1] = 1'b1;
        step();
        rel_valid_i[0] = 1'b0; rel_valid_i[1] = 1'b0;
        check("t3_free0", 32'(q_free_o[0]), 32'd1);
        check("t3_free1", 32'(q_free_o[1]), 32'd1);
        check("t3_idx1", 32'(q_idx_o[1]), 32'd2);
        step();
        check("t3_rr", 32'(dut.rr_ptr_q), 32'd0);

        // 4: overflow during LOCK
        acq_valid_i[1] = 1'b1; acq_idx_i[1] = 2'd0; acq_element_i[1] = 8'h33;
        step();
        acq_valid_i[1] = 1'b0;
        q_overflow_i[1] = 1'b1;
        check("t4_lock_err", 32'(err_overflow_o[1]), 32'd0);
        step();
        q_overflow_i[1] = 1'b0;
        check("t4_err", 32'(err_overflow_o[1]), 32'd1);
        check("t4_idle", 32'(acq_ready_o[1]), 32'd1);
        check("t4_gnt", 32'(gnt_o[1]), 32'd0);
        step();
        check("t4_err_pulse", 32'(err_overflow_o[1]), 32'd0);
        check("t4_gnt_later", 32'(gnt_o[1]), 32'd0);

        // 5: asynchronous reset while HELD
        bring_up(1'b1, 1'b0, 2'd3, 2'd0, 8'h44, 8'h00);
        rst_ni = 1'b0;
        #1;
        check("t5_gnt", 32'(gnt_o[0]), 32'd0);
        check("t5_free", 32'(q_free_o[0]), 32'd0);
        check("t5_ready", 32'(acq_ready_o[0]), 32'd1);
        step();
        rst_ni = 1'b1;
        step();
        check("t5_no_free", 32'(q_free_o[0]), 32'd0);

        // 6: grant withheld for TIMEOUT_CYCLES wait cycles
        acq_valid_i[0] = 1'b1; acq_idx_i[0] = 2'd1; acq_element_i[0] = 8'h66;
        step();
        acq_valid_i[0] = 1'b0;
        step();
        check("t6_w0", 32'(timeout_o[0]), 32'd0);
        repeat (3) step();
        check("t6_w3", 32'(timeout_o[0]), 32'd0);
        step();
`ifdef FRACTAL_SYNC_LOCK_TIMEOUT_EN
        check("t6_w4", 32'(timeout_o[0]), 32'd1);
`else
        check("t6_w4", 32'(timeout_o[0]), 32'd0);
`endif
        check("t6_w4_gnt", 32'(gnt_o[0]), 32'd0);
        q_grant_i[0] = 1'b1; q_element_i[0] = 8'h66;
        step();
        q_grant_i[0] = 1'b0;
        check("t6_held_to", 32'(timeout_o[0]), 32'd0);
        check("t6_held_gnt", 32'(gnt_o[0]), 32'd1);
        check("t6_gelem", 32'(gnt_element_o[0]), 32'h66);
        rel_valid_i[0] = 1'b1;
        step();
        rel_valid_i[0] = 1'b0;
        check("t6_free", 32'(q_free_o[0]), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
